bus_arbit: RTL and testbench

Master-side companion to the bus address decoder. It arbitrates between two bus masters (M0, M1) and drives the single shared request/write/address/write-data set that feeds the decoder and both slaves. It also returns read data to the masters by muxing slave outputs with a one-cycle registered copy of the decoder's slave selects, which matches the synchronous-read slaves.

---
 rtl/bus_pkg.sv | 26 ++
 rtl/bus_arbit_if.sv | 50 +++++
 rtl/bus_arb_fsm.sv | 104 ++++++++++
 rtl/bus_arbit.sv | 88 ++++++++
 tb/tb_bus_arbit.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/bus_pkg.sv
// ============================================================================
// Module  : bus_pkg
// Brief   : Shared types and constants for the two-master bus arbiter.
// Revision: 1.0
// ============================================================================
`default_nettype none

package bus_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 16;

    // Grant state; the encoding doubles as the index of the owning master.
    typedef enum logic [0:0] {
        M0_GRANT = 1'b0,
        M1_GRANT = 1'b1
    } arb_state_t;

    // Registered decoder select codes, ordered {s0_sel, s1_sel}.
    localparam logic [1:0] SEL_S0   = 2'b10;
    localparam logic [1:0] SEL_S1   = 2'b01;
    localparam logic [1:0] SEL_NONE = 2'b00;

endpackage

`default_nettype wire

// File: rtl/bus_arbit_if.sv
// ============================================================================
// Module  : bus_arbit_if
// Brief   : Master, shared-bus and slave-return signals around the arbiter.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface bus_arbit_if #(
    parameter int DATA_W = bus_pkg::DEF_DATA_W,
    parameter int ADDR_W = bus_pkg::DEF_ADDR_W
);

    logic              m0_req;
    logic              m1_req;
    logic              m0_wr;
    logic              m1_wr;
    logic [ADDR_W-1:0] m0_addr;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m0_dout;
    logic [DATA_W-1:0] m1_dout;
    logic              m0_grant;
    logic              m1_grant;

    logic              m_req;
    logic              m_wr;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_dout;

    logic              s0_sel;
    logic              s1_sel;
    logic [DATA_W-1:0] s0_dout;
    logic [DATA_W-1:0] s1_dout;
    logic [DATA_W-1:0] m_din;

    // slave: the arbiter, serving both masters; master: the surrounding system.
    modport slave (
        input  m0_req, m1_req, m0_wr, m1_wr, m0_addr, m1_addr, m0_dout, m1_dout,
        input  s0_sel, s1_sel, s0_dout, s1_dout,
        output m0_grant, m1_grant, m_req, m_wr, m_addr, m_dout, m_din
    );

    modport master (
        output m0_req, m1_req, m0_wr, m1_wr, m0_addr, m1_addr, m0_dout, m1_dout,
        output s0_sel, s1_sel, s0_dout, s1_dout,
        input  m0_grant, m1_grant, m_req, m_wr, m_addr, m_dout, m_din
    );

endinterface

`default_nettype wire

// File: rtl/bus_arb_fsm.sv
// ============================================================================
// Module  : bus_arb_fsm
// Brief   : Two-master grant FSM; optional hold-limit counter under
//           BUS_ARB_TIMEOUT_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module bus_arb_fsm
    import bus_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic m0_req_i,
    input  wire logic m1_req_i,
    output logic      m0_grant_o,
    output logic      m1_grant_o
);

    arb_state_t state_q;
    arb_state_t state_d;
    logic       w_own_req;
    logic       w_oth_req;
    logic       w_force;

    always_comb begin
        w_own_req = (state_q == M0_GRANT) ? m0_req_i : m1_req_i;
        w_oth_req = (state_q == M0_GRANT) ? m1_req_i : m0_req_i;
    end

`ifdef BUS_ARB_TIMEOUT_EN
    localparam int              c_CNT_W     = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [c_CNT_W-1:0] c_HOLD_LAST = c_CNT_W'(MAX_HOLD - 1);

    logic [c_CNT_W-1:0] hold_q;
    logic [c_CNT_W-1:0] hold_d;

    always_comb begin
        w_force = w_own_req && w_oth_req && (hold_q == c_HOLD_LAST);
    end

    // Only contended cycles count; any handover or idle competitor restarts it.
    always_comb begin
        hold_d = hold_q;
        if ((state_d != state_q) || !w_oth_req) begin
            hold_d = '0;
        end else if (w_own_req) begin
            hold_d = hold_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end
`else
    logic w_unused_hold;

    always_comb begin
        w_force       = 1'b0;
        w_unused_hold = (MAX_HOLD == 0);
    end
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            M0_GRANT: begin
                if ((!m0_req_i && m1_req_i) || w_force) begin
                    state_d = M1_GRANT;
                end
            end
            M1_GRANT: begin
                if (!m1_req_i || w_force) begin
                    state_d = M0_GRANT;
                end
            end
            default: begin
                state_d = M0_GRANT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= M0_GRANT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        m0_grant_o = (state_q == M0_GRANT);
        m1_grant_o = (state_q == M1_GRANT);
    end

endmodule

`default_nettype wire

// File: rtl/bus_arbit.sv
// ============================================================================
// Module  : bus_arbit
// Brief   : Two-master bus arbiter with shared-bus mux and registered read
//           return; hold limit enabled by BUS_ARB_TIMEOUT_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module bus_arbit
    import bus_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int MAX_HOLD = 16
) (
    input  wire logic  clk,
    input  wire logic  reset,
    bus_arbit_if.slave bus
);

    logic              w_m0_grant;
    logic              w_m1_grant;
    logic              w_req;
    logic              w_wr;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_dout;
    logic [DATA_W-1:0] w_din;
    logic [1:0]        sel_q;
    logic [1:0]        sel_d;

    bus_arb_fsm #(
        .MAX_HOLD   (MAX_HOLD)
    ) u_fsm (
        .clk        (clk),
        .reset      (reset),
        .m0_req_i   (bus.m0_req),
        .m1_req_i   (bus.m1_req),
        .m0_grant_o (w_m0_grant),
        .m1_grant_o (w_m1_grant)
    );

    // Grant is registered, so the shared bus never glitches on request changes.
    always_comb begin
        w_req  = bus.m0_req;
        w_wr   = bus.m0_wr;
        w_addr = bus.m0_addr;
        w_dout = bus.m0_dout;
        if (w_m1_grant) begin
            w_req  = bus.m1_req;
            w_wr   = bus.m1_wr;
            w_addr = bus.m1_addr;
            w_dout = bus.m1_dout;
        end
    end

    always_comb begin
        sel_d = {bus.s0_sel, bus.s1_sel};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sel_q <= SEL_NONE;
        end else begin
            sel_q <= sel_d;
        end
    end

    // Both-selected is a decoder fault and returns zero like an unmapped read.
    always_comb begin
        w_din = '0;
        case (sel_q)
            SEL_S0:  w_din = bus.s0_dout;
            SEL_S1:  w_din = bus.s1_dout;
            default: w_din = '0;
        endcase
    end

    assign bus.m0_grant = w_m0_grant;
    assign bus.m1_grant = w_m1_grant;
    assign bus.m_req    = w_req;
    assign bus.m_wr     = w_wr;
    assign bus.m_addr   = w_addr;
    assign bus.m_dout   = w_dout;
    assign bus.m_din    = w_din;

endmodule

`default_nettype wire

// File: tb/tb_bus_arbit.sv
// ============================================================================
// Module  : tb_bus_arbit
// Brief   : Self-checking bench for bus_arbit against a behavioural model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_bus_arbit;

    localparam int DW   = 32;
    localparam int AW   = 16;
    localparam int MAXH = 4;
`ifdef BUS_ARB_TIMEOUT_EN
    localparam bit TIMEOUT = 1'b1;
`else
    localparam bit TIMEOUT = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    int   n_chk  = 0;
    int   n_fail = 0;

    // Reference model state: owning master, contended-cycle streak, last selects.
    int         own;
    int         streak;
    logic [1:0] psel;

    always #5 clk = ~clk;

    bus_arbit_if #(.DATA_W(DW), .ADDR_W(AW)) bif ();

    bus_arbit #(
        .DATA_W   (DW),
        .ADDR_W   (AW),
        .MAX_HOLD (MAXH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_m(input int m, input logic req, input logic wr,
                         input logic [AW-1:0] addr, input logic [DW-1:0] data);
        if (m == 0) begin
            bif.m0_req = req; bif.m0_wr = wr; bif.m0_addr = addr; bif.m0_dout = data;
        end else begin
            bif.m1_req = req; bif.m1_wr = wr; bif.m1_addr = addr; bif.m1_dout = data;
        end
    endtask

    task automatic set_s(input logic s0, input logic s1,
                         input logic [DW-1:0] d0, input logic [DW-1:0] d1);
        bif.s0_sel = s0; bif.s1_sel = s1; bif.s0_dout = d0; bif.s1_dout = d1;
    endtask

    // Check outputs against the model, clock once, then advance the model.
    task automatic tick();
        logic [DW-1:0] e_din;
        logic          own_r;
        logic          oth_r;
        #1;
        e_din = (psel == 2'b10) ? bif.s0_dout : (psel == 2'b01) ? bif.s1_dout : '0;
        chk("m0_grant", bif.m0_grant, own == 0);
        chk("m1_grant", bif.m1_grant, own == 1);
        chk("m_req",  bif.m_req,  (own == 0) ? bif.m0_req  : bif.m1_req);
        chk("m_wr",   bif.m_wr,   (own == 0) ? bif.m0_wr   : bif.m1_wr);
        chk("m_addr", bif.m_addr, (own == 0) ? bif.m0_addr : bif.m1_addr);
        chk("m_dout", bif.m_dout, (own == 0) ? bif.m0_dout : bif.m1_dout);
        chk("m_din",  bif.m_din,  e_din);
        @(posedge clk);
        if (reset) begin
            own = 0; streak = 0; psel = 2'b00;
        end else begin
            psel  = {bif.s0_sel, bif.s1_sel};
            own_r = (own == 0) ? bif.m0_req : bif.m1_req;
            oth_r = (own == 0) ? bif.m1_req : bif.m0_req;
            if (!own_r) begin
                own    = oth_r ? 1 - own : 0;
                streak = 0;
            end else if (oth_r) begin
                streak++;
                if (TIMEOUT && streak >= MAXH) begin
                    own    = 1 - own;
                    streak = 0;
                end
            end else begin
                streak = 0;
            end
        end
        #1;
    endtask

    initial begin
        own = 0; streak = 0; psel = 2'b00;
        reset = 1'b1;
        set_m(0, 1'b0, 1'b0, 16'h1234, 32'h0000_1111);
        set_m(1, 1'b0, 1'b0, 16'h5678, 32'h0000_2222);
        set_s(1'b0, 1'b0, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        #1;

        // Reset state, no requests
        tick();
        chk("rst_m_addr", bif.m_addr, 16'h1234);
        reset = 1'b0;
        tick();

        // M1 write handover from park
        set_m(1, 1'b1, 1'b1, 16'h7004, 32'hA5A5_A5A5);
        tick();
        chk("m1_grant_after", bif.m1_grant, 1'b1);
        chk("m1_wr_addr", bif.m_addr, 16'h7004);
        chk("m1_wr_data", bif.m_dout, 32'hA5A5_A5A5);
        tick();

        // M1 drops, M0 reads 0x0010 from s0
        set_m(1, 1'b0, 1'b0, 16'h7004, 32'h0);
        set_m(0, 1'b1, 1'b0, 16'h0010, 32'h0);
        tick();
        set_s(1'b1, 1'b0, 32'h0, 32'h0);
        tick();
        set_s(1'b0, 1'b0, 32'h1234_5678, 32'hDEAD_BEEF);
        set_m(0, 1'b1, 1'b0, 16'h4000, 32'h0);
        #1 chk("s0_read_data", bif.m_din, 32'h1234_5678);
        tick();

        // Unmapped read returns zero
        set_s(1'b0, 1'b0, 32'hCAFE_F00D, 32'hBEEF_CAFE);
        #1 chk("unmapped_read", bif.m_din, 32'h0);
        tick();

        // Contention while M1 owns, then M1 releases
        set_m(0, 1'b0, 1'b0, 16'h0, 32'h0);
        set_m(1, 1'b1, 1'b0, 16'h0200, 32'h0);
        tick();
        set_m(0, 1'b1, 1'b1, 16'h0300, 32'h3333_3333);
        repeat (3) tick();
        chk("m1_keeps_bus", bif.m1_grant, 1'b1);
        set_m(1, 1'b0, 1'b0, 16'h0200, 32'h0);
        tick();
        chk("m0_after_release", bif.m0_grant, 1'b1);
        chk("one_hot", bif.m0_grant ^ bif.m1_grant, 1'b1);

        // Sustained contention from M0 ownership
        set_m(1, 1'b1, 1'b1, 16'h0400, 32'h4444_4444);
        repeat (20) tick();

        // Reset in the middle of an M1 read
        set_m(0, 1'b0, 1'b0, 16'h0, 32'h0);
        repeat (2) tick();
        set_s(1'b0, 1'b1, 32'h0, 32'h0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        set_s(1'b0, 1'b0, 32'h1111_2222, 32'h3333_4444);
        #1 chk("rst_inflight_din", bif.m_din, 32'h0);
        chk("rst_grant", bif.m0_grant, 1'b1);
        tick();

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            set_m(0, ($urandom_range(0, 9) < 7), 1'($urandom), AW'($urandom), $urandom);
            set_m(1, ($urandom_range(0, 9) < 7), 1'($urandom), AW'($urandom), $urandom);
            set_s(1'($urandom), 1'($urandom), $urandom, $urandom);
            reset = ($urandom_range(0, 63) == 0);
            tick();
        end
        reset = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
